// File: rtl/seq_win_scanner.sv
// Sequential NxN win/draw/overlap checker: evaluates one board line per clock after a start pulse.
// Optional SEQ_WIN_EARLY_EXIT_EN: finish on the first winning line instead of scanning all lines.
module seq_win_scanner #(
  parameter int N = 3,
  localparam int LW = 2*N+2
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N*N-1:0] ain,
  input  logic [N*N-1:0] bin,
  output logic           busy,
  output logic           done,
  output logic [LW-1:0]  win_line,
  output logic [1:0]     winner,
  output logic           draw,
  output logic           err
);
  localparam int CW = $clog2(LW);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  // Cell mask of line idx: rows, then columns, then main and anti diagonal.
  function automatic logic [N*N-1:0] line_mask(input int idx);
    logic [N*N-1:0] m;
    m = '0;
    for (int r = 0; r < N; r++) begin
      for (int c = 0; c < N; c++) begin
        if ((idx < N && r == idx) ||
            (idx >= N && idx < 2*N && c == idx - N) ||
            (idx == 2*N && r == c) ||
            (idx == 2*N+1 && r + c == N-1))
          m[N*N-1-(r*N+c)] = 1'b1;
      end
    end
    return m;
  endfunction

  logic [LW-1:0][N*N-1:0] masks;
  for (genvar gi = 0; gi < LW; gi++) begin : g_mask
    assign masks[gi] = line_mask(gi);
  end

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N*N-1:0] snap_a_q, snap_a_d, snap_b_q, snap_b_d;
  logic [LW-1:0]  acc_q, acc_d;
  logic           any_a_q, any_a_d, any_b_q, any_b_d;
  logic [LW-1:0]  win_line_q, win_line_d;
  logic [1:0]     winner_q, winner_d;
  logic           draw_q, draw_d, err_q, err_d;

  logic line_a, line_b, hit, last, finish;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    snap_a_d   = snap_a_q;
    snap_b_d   = snap_b_q;
    acc_d      = acc_q;
    any_a_d    = any_a_q;
    any_b_d    = any_b_q;
    win_line_d = win_line_q;
    winner_d   = winner_q;
    draw_d     = draw_q;
    err_d      = err_q;

    line_a = (snap_a_q & masks[cnt_q]) == masks[cnt_q];
    line_b = (snap_b_q & masks[cnt_q]) == masks[cnt_q];
    hit    = line_a | line_b;
    last   = cnt_q == CW'(LW-1);
`ifdef SEQ_WIN_EARLY_EXIT_EN
    finish = last | hit;
`else
    finish = last;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          snap_a_d = ain;
          snap_b_d = bin;
          acc_d    = '0;
          any_a_d  = 1'b0;
          any_b_d  = 1'b0;
          cnt_d    = '0;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        acc_d[cnt_q] = hit;
        any_a_d      = any_a_q | line_a;
        any_b_d      = any_b_q | line_b;
        cnt_d        = cnt_q + 1'b1;
        // Results are published on DONE entry so they include the final line.
        if (finish) begin
          state_d    = DONE;
          win_line_d = acc_d;
          winner_d   = {any_b_d, any_a_d};
          draw_d     = (&(snap_a_q | snap_b_q)) && (acc_d == '0);
          err_d      = |(snap_a_q & snap_b_q);
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      snap_a_q   <= '0;
      snap_b_q   <= '0;
      acc_q      <= '0;
      any_a_q    <= 1'b0;
      any_b_q    <= 1'b0;
      win_line_q <= '0;
      winner_q   <= 2'b00;
      draw_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      snap_a_q   <= snap_a_d;
      snap_b_q   <= snap_b_d;
      acc_q      <= acc_d;
      any_a_q    <= any_a_d;
      any_b_q    <= any_b_d;
      win_line_q <= win_line_d;
      winner_q   <= winner_d;
      draw_q     <= draw_d;
      err_q      <= err_d;
    end
  end

  assign busy     = state_q != IDLE;
  assign done     = state_q == DONE;
  assign win_line = win_line_q;
  assign winner   = winner_q;
  assign draw     = draw_q;
  assign err      = err_q;
endmodule
